mem_port_arbiter: RTL and testbench

Shares the single-ported data/instruction RAM between the instruction-fetch stage (read-only) and the MEM stage (read/write). Each requester uses a hold-until-done handshake, and the RAM uses a req/ack handshake with variable latency. The arbiter registers the winning request, sequences one RAM transaction at a time, returns read data with a one-cycle done pulse, and exports stall requests to the pipeline controller.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_port_arbiter_pick.sv | 24 ++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter shared types: FSM states, owner ids, full-word byte enable.
// MEM_ARB_RR_EN selects round-robin tie-break instead of fixed MEM > IF.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM handshake bundle for mem_port_arbiter.
// slave = arbiter side, master = pipeline/RAM side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              if_stall;

  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;
  logic              mem_stall;

  logic              ram_req;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ack;

  modport slave (
    input  if_req, if_addr,
    input  mem_req, mem_we, mem_be,
    input  mem_addr, mem_wdata,
    input  ram_rdata, ram_ack,
    output if_rdata, if_done, if_stall,
    output mem_rdata, mem_done, mem_stall,
    output ram_req, ram_we, ram_be,
    output ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr,
    output mem_req, mem_we, mem_be,
    output mem_addr, mem_wdata,
    output ram_rdata, ram_ack,
    input  if_rdata, if_done, if_stall,
    input  mem_rdata, mem_done, mem_stall,
    input  ram_req, ram_we, ram_be,
    input  ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// arb_pick: chooses the RAM owner from the two requests.
// MEM_ARB_RR_EN adds a last-grant input for round-robin ties.
module arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic   i_if_req,
  input  logic   i_mem_req,
`ifdef MEM_ARB_RR_EN
  input  owner_t i_last_grant,
`endif
  output owner_t o_owner
);
  always_comb begin
    o_owner = OWN_IF;
    if (i_mem_req)
      o_owner = OWN_MEM;
`ifdef MEM_ARB_RR_EN
    // on a tie the side not served last wins
    if (i_mem_req && i_if_req)
      o_owner = (i_last_grant == OWN_IF) ?
                OWN_MEM : OWN_IF;
`endif
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one RAM transaction at a time for fetch and MEM.
// Define MEM_ARB_RR_EN for round-robin ties (default strict MEM > IF).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  arb_state_t        r_state, w_next;
  owner_t            r_owner, w_pick;
  logic              r_ram_req;
  logic              r_if_done, r_mem_done;
  logic              r_we;
  logic [3:0]        r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_if_rdata, r_mem_rdata;
  logic              w_grant, w_ack;
`ifdef MEM_ARB_RR_EN
  owner_t            r_last;
`endif

  arb_pick u_pick (
    .i_if_req     (bus.if_req),
    .i_mem_req    (bus.mem_req),
`ifdef MEM_ARB_RR_EN
    .i_last_grant (r_last),
`endif
    .o_owner      (w_pick)
  );

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_ack   = 1'b0;
    unique case (r_state)
      ARB_IDLE: if (bus.if_req || bus.mem_req) begin
        w_next  = ARB_BUSY;
        w_grant = 1'b1;
      end
      ARB_BUSY: if (bus.ram_ack) begin
        w_next = ARB_RESP;
        w_ack  = 1'b1;
      end
      ARB_RESP: w_next = ARB_IDLE;
      default:  w_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ARB_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner     <= OWN_IF;
      r_ram_req   <= 1'b0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_we        <= 1'b0;
      r_be        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else begin
      r_if_done  <= 1'b0;
      r_mem_done <= 1'b0;
      if (w_grant) begin
        r_owner   <= w_pick;
        r_ram_req <= 1'b1;
        if (w_pick == OWN_MEM) begin
          r_we    <= bus.mem_we;
          r_be    <= bus.mem_be;
          r_addr  <= bus.mem_addr;
          r_wdata <= bus.mem_wdata;
        end else begin
          r_we    <= 1'b0;
          r_be    <= BE_WORD;
          r_addr  <= bus.if_addr;
          r_wdata <= '0;
        end
      end
      if (w_ack) begin
        r_ram_req <= 1'b0;
        if (r_owner == OWN_IF) begin
          r_if_done  <= 1'b1;
          r_if_rdata <= bus.ram_rdata;
        end else begin
          r_mem_done <= 1'b1;
          // a write leaves the last read value visible
          if (!r_we)
            r_mem_rdata <= bus.ram_rdata;
        end
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_last <= OWN_IF;
    else if (w_grant) r_last <= w_pick;
  end
`endif

  assign bus.ram_req   = r_ram_req;
  assign bus.ram_we    = r_we;
  assign bus.ram_be    = r_be;
  assign bus.ram_addr  = r_addr;
  assign bus.ram_wdata = r_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.mem_rdata = r_mem_rdata;
  assign bus.if_done   = r_if_done;
  assign bus.mem_done  = r_mem_done;
  assign bus.if_stall  = bus.if_req & ~r_if_done;
  assign bus.mem_stall = bus.mem_req & ~r_mem_done;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed cases plus random traffic against a
// transaction-level reference model.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  int          cfg_wait  = -1;
  bit          cfg_rnd   = 1'b1;
  logic [31:0] cfg_rdata = '0;
  bit          spur_en   = 1'b0;
  bit          force_ack = 1'b0;
  bit          seen_if_done, seen_mem_done;

  // reference model: the transaction in flight and its response
  logic        m_active, m_resp, m_own_mem, m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_if_rd, m_mem_rd;
  wire         m_pick_mem;
`ifdef MEM_ARB_RR_EN
  logic        m_last_mem;
  assign m_pick_mem = bus.mem_req & (~bus.if_req | ~m_last_mem);
`else
  assign m_pick_mem = bus.mem_req;
`endif

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit is_mem, input int bound,
                           output int n);
    n = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (is_mem ? bus.mem_done : bus.if_done) return;
      n++;
    end
    n = -1;
    n_chk++;
    n_err++;
    $display("FAIL done_timeout: mem=%0d no done in %0d cycles",
             is_mem, bound);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active  <= 1'b0;
      m_resp    <= 1'b0;
      m_own_mem <= 1'b0;
      m_we      <= 1'b0;
      m_be      <= '0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_if_rd   <= '0;
      m_mem_rd  <= '0;
`ifdef MEM_ARB_RR_EN
      m_last_mem <= 1'b0;
`endif
    end else if (m_resp) begin
      m_resp <= 1'b0;
    end else if (m_active) begin
      if (bus.ram_ack) begin
        m_active <= 1'b0;
        m_resp   <= 1'b1;
        if (!m_own_mem)  m_if_rd  <= bus.ram_rdata;
        else if (!m_we)  m_mem_rd <= bus.ram_rdata;
      end
    end else if (bus.if_req || bus.mem_req) begin
      m_active  <= 1'b1;
      m_own_mem <= m_pick_mem;
`ifdef MEM_ARB_RR_EN
      m_last_mem <= m_pick_mem;
`endif
      m_we    <= m_pick_mem ? bus.mem_we    : 1'b0;
      m_be    <= m_pick_mem ? bus.mem_be    : 4'hF;
      m_addr  <= m_pick_mem ? bus.mem_addr  : bus.if_addr;
      m_wdata <= m_pick_mem ? bus.mem_wdata : 32'h0;
    end
  end

  // per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    seen_if_done  = bus.if_done;
    seen_mem_done = bus.mem_done;
    if (chk_en) begin
      chk("ram_req",   bus.ram_req,   m_active);
      chk("ram_we",    bus.ram_we,    m_we);
      chk("ram_be",    bus.ram_be,    m_be);
      chk("ram_addr",  bus.ram_addr,  m_addr);
      chk("ram_wdata", bus.ram_wdata, m_wdata);
      chk("if_done",   bus.if_done,   m_resp & ~m_own_mem);
      chk("mem_done",  bus.mem_done,  m_resp & m_own_mem);
      chk("if_rdata",  bus.if_rdata,  m_if_rd);
      chk("mem_rdata", bus.mem_rdata, m_mem_rd);
      chk("if_stall",  bus.if_stall,
          bus.if_req & ~(m_resp & ~m_own_mem));
      chk("mem_stall", bus.mem_stall,
          bus.mem_req & ~(m_resp & m_own_mem));
    end
  end

  // RAM responder with configurable wait states
  initial begin
    int  w_left;
    bit  prev_req;
    w_left   = 0;
    prev_req = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.ram_ack   = 1'b0;
      bus.ram_rdata = $urandom;
      if (bus.ram_req) begin
        if (!prev_req)
          w_left = (cfg_wait < 0) ?
                   int'($urandom_range(0, 3)) : cfg_wait;
        if (w_left == 0) begin
          bus.ram_ack = 1'b1;
          if (!cfg_rnd) bus.ram_rdata = cfg_rdata;
        end else begin
          w_left--;
        end
      end else if (force_ack ||
                   (spur_en && $urandom_range(0, 3) == 0)) begin
        bus.ram_ack = 1'b1;
      end
      prev_req = bus.ram_req;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ram_req",   bus.ram_req,   0);
    chk("rst_ram_addr",  bus.ram_addr,  0);
    chk("rst_ram_be",    bus.ram_be,    0);
    chk("rst_if_done",   bus.if_done,   0);
    chk("rst_mem_rdata", bus.mem_rdata, 0);
    chk_en = 1'b1;

    // single fetch, two wait states
    step();
    cfg_wait  = 2;
    cfg_rnd   = 1'b0;
    cfg_rdata = 32'h2402_0005;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0040;
    @(negedge clk);
    chk("f_stall_t",  bus.if_stall, 1);
    chk("f_req_t",    bus.ram_req,  0);
    @(negedge clk);
    chk("f_req",  bus.ram_req,  1);
    chk("f_addr", bus.ram_addr, 32'h40);
    chk("f_we",   bus.ram_we,   0);
    chk("f_be",   bus.ram_be,   4'hF);
    wait_done(1'b0, 20, n);
    chk("f_lat",   n,            2);
    chk("f_rdata", bus.if_rdata, 32'h2402_0005);
    chk("f_stall", bus.if_stall, 0);
    step();
    bus.if_req = 1'b0;
    @(negedge clk);
    chk("f_done_once", bus.if_done,  0);
    chk("f_hold",      bus.if_rdata, 32'h2402_0005);

    // simultaneous requests: MEM write first
    step();
    cfg_wait      = 1;
    cfg_rnd       = 1'b1;
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_be    = 4'b0011;
    bus.mem_addr  = 32'h100;
    bus.mem_wdata = 32'hDEAD_BEEF;
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h200;
    @(negedge clk);
    @(negedge clk);
    chk("s_addr",  bus.ram_addr,  32'h100);
    chk("s_wdata", bus.ram_wdata, 32'hDEAD_BEEF);
    chk("s_be",    bus.ram_be,    4'b0011);
    chk("s_we",    bus.ram_we,    1);
    wait_done(1'b1, 20, n);
    chk("s_wr_keeps", bus.mem_rdata, 0);
    step();
`ifdef MEM_ARB_RR_EN
    bus.mem_we   = 1'b0;
    bus.mem_addr = 32'h104;
`else
    bus.mem_req  = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    chk("s_if_next", bus.ram_addr, 32'h200);
    chk("s_if_we",   bus.ram_we,   0);
    wait_done(1'b0, 20, n);
    step();
    bus.if_req = 1'b0;
`ifdef MEM_ARB_RR_EN
    wait_done(1'b1, 20, n);
    step();
    bus.mem_req = 1'b0;
`endif

    // zero-wait RAM
    step();
    cfg_wait     = 0;
    cfg_rnd      = 1'b0;
    cfg_rdata    = 32'hA5A5_0001;
    bus.mem_req  = 1'b1;
    bus.mem_we   = 1'b0;
    bus.mem_be   = 4'hF;
    bus.mem_addr = 32'h300;
    @(negedge clk);
    wait_done(1'b1, 20, n);
    chk("z_lat",    n,             1);
    chk("z_req",    bus.ram_req,   0);
    chk("z_rdata",  bus.mem_rdata, 32'hA5A5_0001);
    step();
    bus.mem_req = 1'b0;

    // spurious acks while idle
    force_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("sp_if_done",  bus.if_done,   0);
      chk("sp_mem_done", bus.mem_done,  0);
      chk("sp_mrd",      bus.mem_rdata, 32'hA5A5_0001);
    end
    step();
    force_ack = 1'b0;

    // reset in the middle of BUSY
    step();
    cfg_wait     = 5;
    bus.mem_req  = 1'b1;
    bus.mem_addr = 32'h400;
    @(negedge clk);
    @(negedge clk);
    chk("r_busy", bus.ram_req, 1);
    step();
    rst         = 1'b1;
    bus.mem_req = 1'b0;
    #1;
    chk("r_req",   bus.ram_req,   0);
    chk("r_done",  bus.mem_done,  0);
    chk("r_mrd",   bus.mem_rdata, 0);
    chk("r_ifrd",  bus.if_rdata,  0);
    chk("r_addr",  bus.ram_addr,  0);
    step();
    rst       = 1'b0;
    force_ack = 1'b1;
    step();
    step();
    force_ack = 1'b0;
    @(negedge clk);
    chk("r_late_done", bus.mem_done,  0);
    chk("r_late_rd",   bus.mem_rdata, 0);
    step();
    cfg_wait     = 1;
    cfg_rdata    = 32'h1234_5678;
    bus.mem_req  = 1'b1;
    bus.mem_addr = 32'h404;
    wait_done(1'b1, 20, n);
    chk("r_fresh", bus.mem_rdata, 32'h1234_5678);
    step();
    bus.mem_req = 1'b0;

    // back-to-back MEM reads
    step();
    cfg_rdata    = 32'h1111_0001;
    bus.mem_req  = 1'b1;
    bus.mem_addr = 32'h500;
    wait_done(1'b1, 20, n);
    chk("b1_rd", bus.mem_rdata, 32'h1111_0001);
    cfg_rdata = 32'h2222_0002;
    step();
    bus.mem_addr = 32'h504;
    @(negedge clk);
    chk("b_idle_req", bus.ram_req, 0);
    @(negedge clk);
    chk("b2_req",  bus.ram_req,  1);
    chk("b2_addr", bus.ram_addr, 32'h504);
    wait_done(1'b1, 20, n);
    chk("b2_rd", bus.mem_rdata, 32'h2222_0002);
    step();
    bus.mem_req = 1'b0;

    // random traffic
    cfg_wait = -1;
    cfg_rnd  = 1'b1;
    spur_en  = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (bus.if_req) begin
        if (seen_if_done) begin
          if ($urandom_range(0, 3) == 0) bus.if_addr = $urandom;
          else                           bus.if_req  = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        bus.if_req  = 1'b1;
        bus.if_addr = $urandom;
      end
      if (bus.mem_req) begin
        if (seen_mem_done) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.mem_we    = 1'($urandom);
            bus.mem_be    = 4'($urandom);
            bus.mem_addr  = $urandom;
            bus.mem_wdata = $urandom;
          end else begin
            bus.mem_req = 1'b0;
          end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'($urandom);
        bus.mem_be    = 4'($urandom);
        bus.mem_addr  = $urandom;
        bus.mem_wdata = $urandom;
      end
    end
    for (int c = 0; c < 100; c++) begin
      step();
      if (bus.if_req && seen_if_done)   bus.if_req  = 1'b0;
      if (bus.mem_req && seen_mem_done) bus.mem_req = 1'b0;
    end
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
